riot_multiport: RTL

Parametrised successor to the 6530 RRIOT I/O-and-timer core. It provides NUM_PORTS bidirectional ports of PORT_W bits, each with its own data register and DDR. It also provides an 8-bit interval timer with a 6532-style selectable prescaler and a fast-count phase after underflow. It sits behind the pad SB_IO ring, receives registered bus signals clocked on phi2, and drives DDR nets straight to the pad output enables.

---
 rtl/riot_pkg.sv | 34 +++
 rtl/riot_timer.sv | 74 +++++++
 rtl/riot_multiport.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/riot_pkg.sv
// ============================================================================
// riot_pkg : shared types, address fields and flag positions.   Rev 1.0
// ============================================================================
`default_nettype none

package riot_pkg;

  typedef enum logic [1:0] {
    PS_1    = 2'b00,
    PS_8    = 2'b01,
    PS_64   = 2'b10,
    PS_1024 = 2'b11
  } prescale_e;

  localparam int REGION_BIT = 4;
  localparam int IDX_MSB    = 3;
  localparam int IDX_LSB    = 1;
  localparam int SEL_BIT    = 0;

  localparam int TFLAG_BIT  = 7;
  localparam int EFLAG_BIT  = 6;

  function automatic logic [9:0] prescale_div_m1(input prescale_e ps);
    case (ps)
      PS_1:    prescale_div_m1 = 10'd0;
      PS_8:    prescale_div_m1 = 10'd7;
      PS_64:   prescale_div_m1 = 10'd63;
      default: prescale_div_m1 = 10'd1023;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/riot_timer.sv
// ============================================================================
// riot_timer : 8-bit interval timer, selectable prescaler, fast phase.  Rev 1.0
// ============================================================================
`default_nettype none

module riot_timer
  import riot_pkg::*;
(
  input  logic       phi2,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  prescale_e  prescale,
  input  logic       clr_flag,
  output logic [7:0] count,
  output logic       tflag
);

  logic [7:0] count_q, count_d;
  logic [9:0] pc_q, pc_d;
  prescale_e  prescale_q, prescale_d;
  logic       fast_q, fast_d;
  logic       tflag_q, tflag_d;

  always_comb begin
    count_d    = count_q;
    pc_d       = pc_q;
    prescale_d = prescale_q;
    fast_d     = fast_q;
    tflag_d    = tflag_q;
    if (load) begin
      count_d    = load_val;
      prescale_d = prescale;
      pc_d       = prescale_div_m1(prescale);
      fast_d     = 1'b0;
      tflag_d    = 1'b0;
    end else begin
      if (clr_flag) tflag_d = 1'b0;
      if (pc_q != 10'd0) begin
        pc_d = pc_q - 10'd1;
      end else begin
        count_d = count_q - 8'd1;
        if (count_q == 8'h00) begin
          tflag_d = 1'b1;
          fast_d  = 1'b1;
        end
        // Post-underflow reload uses the updated fast bit so counting is /1 at once.
        pc_d = fast_d ? 10'd0 : prescale_div_m1(prescale_q);
      end
    end
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      count_q    <= 8'h00;
      pc_q       <= prescale_div_m1(PS_1024);
      prescale_q <= PS_1024;
      fast_q     <= 1'b0;
      tflag_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      pc_q       <= pc_d;
      prescale_q <= prescale_d;
      fast_q     <= fast_d;
      tflag_q    <= tflag_d;
    end
  end

  assign count = count_q;
  assign tflag = tflag_q;

endmodule

`default_nettype wire

// File: rtl/riot_multiport.sv
// ============================================================================
// riot_multiport : N-port RIOT I/O block with interval timer.  Rev 1.0
// Optional edge interrupt on port 0 pin EDGE_PIN: define RIOT_EDGE_IRQ_EN.
// ============================================================================
`default_nettype none

module riot_multiport
  import riot_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 8,
  parameter int EDGE_PIN  = 7
) (
  input  logic                        phi2,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        we_n,
  input  logic [4:0]                  addr,
  input  logic [7:0]                  di,
  output logic [7:0]                  do_,
  output logic                        oe,
  input  logic [NUM_PORTS*PORT_W-1:0] pi,
  output logic [NUM_PORTS*PORT_W-1:0] po,
  output logic [NUM_PORTS*PORT_W-1:0] ddr,
  output logic                        irq_n
);

  localparam int PW = NUM_PORTS * PORT_W;

  if (EDGE_PIN >= PORT_W) begin : g_edge_pin_check
    $error("EDGE_PIN must be below PORT_W");
  end

  logic [2:0] idx;
  logic       timer_sel, sel, wr, rd, port_wr, tmr_load, tmr_rd;
  logic [7:0] port_rd, flag_byte, count;
  logic       tflag, eflag, eie;
  logic [PW-1:0] po_q, po_d, ddr_q, ddr_d;
  logic       tie_q, tie_d, irq_n_q, irq_n_d;

  assign idx       = addr[IDX_MSB:IDX_LSB];
  assign timer_sel = addr[REGION_BIT];
  assign sel       = addr[SEL_BIT];
  assign wr        = cs & ~we_n;
  assign rd        = cs & we_n;
  assign port_wr   = wr & ~timer_sel;
  assign tmr_load  = wr & timer_sel & ~sel;
  assign tmr_rd    = rd & timer_sel & ~sel;

  // Indices at or above NUM_PORTS match no loop entry: writes drop, reads give 0.
  always_comb begin
    po_d    = po_q;
    ddr_d   = ddr_q;
    port_rd = 8'h00;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (idx == 3'(n)) begin
        if (port_wr) begin
          if (sel) ddr_d[n*PORT_W +: PORT_W] = di[PORT_W-1:0];
          else     po_d[n*PORT_W +: PORT_W]  = di[PORT_W-1:0];
        end
        port_rd = sel ? 8'(ddr_q[n*PORT_W +: PORT_W])
                      : 8'((ddr_q[n*PORT_W +: PORT_W] & po_q[n*PORT_W +: PORT_W]) |
                           (~ddr_q[n*PORT_W +: PORT_W] & pi[n*PORT_W +: PORT_W]));
      end
    end
  end

  riot_timer u_timer (
    .phi2     (phi2),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (di),
    .prescale (prescale_e'(addr[3:2])),
    .clr_flag (tmr_rd),
    .count    (count),
    .tflag    (tflag)
  );

`ifdef RIOT_EDGE_IRQ_EN
  logic ectl_wr, flag_rd, edge_hit;
  logic eie_q, eie_d, epol_q, epol_d, eflag_q, eflag_d, prev_q;

  assign ectl_wr = wr & timer_sel & sel;
  assign flag_rd = rd & timer_sel & sel;

  always_comb begin
    eie_d    = eie_q;
    epol_d   = epol_q;
    if (ectl_wr) begin
      eie_d  = di[1];
      epol_d = di[0];
    end
    edge_hit = epol_q ? (~prev_q & pi[EDGE_PIN]) : (prev_q & ~pi[EDGE_PIN]);
    eflag_d  = eflag_q;
    if (flag_rd)  eflag_d = 1'b0;
    if (edge_hit) eflag_d = 1'b1;
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      eie_q   <= 1'b0;
      epol_q  <= 1'b0;
      eflag_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      eie_q   <= eie_d;
      epol_q  <= epol_d;
      eflag_q <= eflag_d;
      prev_q  <= pi[EDGE_PIN];
    end
  end

  assign eflag = eflag_q;
  assign eie   = eie_q;
`else
  assign eflag = 1'b0;
  assign eie   = 1'b0;
`endif

  always_comb begin
    flag_byte            = 8'h00;
    flag_byte[TFLAG_BIT] = tflag;
    flag_byte[EFLAG_BIT] = eflag;
    tie_d                = (tmr_load | tmr_rd) ? addr[1] : tie_q;
    irq_n_d              = ~((tflag & tie_q) | (eflag & eie));
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      po_q    <= '0;
      ddr_q   <= '0;
      tie_q   <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      po_q    <= po_d;
      ddr_q   <= ddr_d;
      tie_q   <= tie_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign do_   = timer_sel ? (sel ? flag_byte : count) : port_rd;
  assign oe    = cs & we_n;
  assign po    = po_q;
  assign ddr   = ddr_q;
  assign irq_n = irq_n_q;

endmodule

`default_nettype wire
